cve2_alu_arbiter: RTL and testbench

//  Shares one cve2 ALU instance between two requesters (0 = core issue path, 1 = test/stimulus port).

---
 rtl/cve2_alu_arbiter.sv | 132 +++++++++++++
 tb/tb_cve2_alu_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cve2_alu_arbiter.sv
// Round-robin arbiter sharing one cve2 ALU between the core issue path and a test port.
// Holds the winning op, the ALU intermediate values and the result until the owner takes it.
module cve2_alu_arbiter #(
    parameter int unsigned MAX_CYC = 2,
    parameter int unsigned OP_W    = 7
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [1:0]        req_valid_i,
    output logic [1:0]        req_ready_o,
    input  logic [2*OP_W-1:0] req_op_i,
    input  logic [63:0]       req_a_i,
    input  logic [63:0]       req_b_i,
    input  logic [3:0]        req_ncyc_i,
    output logic [1:0]        resp_valid_o,
    input  logic [1:0]        resp_ready_i,
    output logic [31:0]       resp_result_o,
    output logic [OP_W-1:0]   alu_operator_o,
    output logic [31:0]       alu_operand_a_o,
    output logic [31:0]       alu_operand_b_o,
    output logic              alu_instr_first_cycle_o,
    output logic [63:0]       alu_imd_val_q_o,
    input  logic [63:0]       alu_imd_val_d_i,
    input  logic [1:0]        alu_imd_val_we_i,
    input  logic [31:0]       alu_result_i,
    output logic [1:0]        grant_o,
    output logic              busy_o
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_e;

    localparam logic [1:0] MAX_N = 2'(MAX_CYC);

    state_e           state_q, state_d;
    logic             rr_last_q;
    logic             owner_q;
    logic [OP_W-1:0]  op_q;
    logic [31:0]      a_q, b_q, result_q;
    logic [1:0]       ncyc_q, cnt_q;
    logic [1:0][31:0] imd_q;

    logic             win;
    logic             accept;
    logic             done;
    logic [1:0]       ncyc_sel, ncyc_clamp;

    always_comb begin
        win = 1'b0;
        case (req_valid_i)
            2'b01:   win = 1'b0;
            2'b10:   win = 1'b1;
            2'b11:   win = ~rr_last_q;
            default: win = 1'b0;
        endcase
    end

    assign accept      = (state_q == IDLE) && (|req_valid_i);
    assign req_ready_o = accept ? (2'b01 << win) : 2'b00;
    assign done        = (state_q == EXEC) && (cnt_q == ncyc_q);

    // A zero cycle count still needs one ALU cycle; long ops saturate at MAX_CYC.
    always_comb begin
        ncyc_sel   = win ? req_ncyc_i[3:2] : req_ncyc_i[1:0];
        ncyc_clamp = ncyc_sel;
        if (ncyc_sel == 2'd0) begin
            ncyc_clamp = 2'd1;
        end else if (ncyc_sel > MAX_N) begin
            ncyc_clamp = MAX_N;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = EXEC;
            EXEC:    if (done) state_d = RESP;
            RESP:    if (resp_ready_i[owner_q]) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            rr_last_q <= 1'b1;
            owner_q   <= 1'b0;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            ncyc_q    <= '0;
            cnt_q     <= '0;
            imd_q     <= '0;
            result_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                owner_q <= win;
                op_q    <= win ? req_op_i[2*OP_W-1:OP_W] : req_op_i[OP_W-1:0];
                a_q     <= win ? req_a_i[63:32] : req_a_i[31:0];
                b_q     <= win ? req_b_i[63:32] : req_b_i[31:0];
                ncyc_q  <= ncyc_clamp;
                cnt_q   <= 2'd1;
                imd_q   <= '0;
            end
            if (state_q == EXEC) begin
                for (int k = 0; k < 2; k++) begin
                    if (alu_imd_val_we_i[k]) imd_q[k] <= alu_imd_val_d_i[k*32 +: 32];
                end
                if (done) result_q <= alu_result_i;
                else      cnt_q    <= cnt_q + 2'd1;
            end
            if ((state_q == RESP) && resp_ready_i[owner_q]) begin
                rr_last_q <= owner_q;
            end
        end
    end

    assign resp_valid_o            = (state_q == RESP) ? (2'b01 << owner_q) : 2'b00;
    assign grant_o                 = (state_q != IDLE) ? (2'b01 << owner_q) : 2'b00;
    assign busy_o                  = (state_q != IDLE);
    assign resp_result_o           = result_q;
    assign alu_operator_o          = op_q;
    assign alu_operand_a_o         = a_q;
    assign alu_operand_b_o         = b_q;
    assign alu_instr_first_cycle_o = (state_q == EXEC) && (cnt_q == 2'd1);
    assign alu_imd_val_q_o         = {imd_q[1], imd_q[0]};

endmodule

// File: tb/tb_cve2_alu_arbiter.sv
// Directed bench for cve2_alu_arbiter: stimulus pushes expected responses,
// a monitor pops and compares them on every response handshake.
module tb_cve2_alu_arbiter;

    localparam int OP_W = 7;
    localparam logic [6:0] OP_ADD = 7'd0;
    localparam logic [6:0] OP_SUB = 7'd1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [1:0]        req_valid = '0;
    logic [1:0]        req_ready;
    logic [2*OP_W-1:0] req_op = '0;
    logic [63:0]       req_a = '0;
    logic [63:0]       req_b = '0;
    logic [3:0]        req_ncyc = '0;
    logic [1:0]        resp_valid;
    logic [1:0]        resp_ready = 2'b11;
    logic [31:0]       resp_result;
    logic [OP_W-1:0]   alu_op;
    logic [31:0]       alu_a, alu_b;
    logic              alu_first;
    logic [63:0]       imd_q;
    logic [63:0]       imd_d = '0;
    logic [1:0]        imd_we = '0;
    logic [31:0]       alu_res;
    logic [1:0]        grant;
    logic              busy;

    int vectors = 0;
    int miscompares = 0;
    logic [32:0] exp_q[$];

    always #5 clk = ~clk;

    // Tiny stand-in ALU: SUB for operator 1, ADD otherwise.
    assign alu_res = (alu_op == OP_SUB) ? (alu_a - alu_b) : (alu_a + alu_b);

    cve2_alu_arbiter #(.MAX_CYC(2), .OP_W(OP_W)) dut (
        .clk_i                  (clk),
        .rst_ni                 (rst_n),
        .req_valid_i            (req_valid),
        .req_ready_o            (req_ready),
        .req_op_i               (req_op),
        .req_a_i                (req_a),
        .req_b_i                (req_b),
        .req_ncyc_i             (req_ncyc),
        .resp_valid_o           (resp_valid),
        .resp_ready_i           (resp_ready),
        .resp_result_o          (resp_result),
        .alu_operator_o         (alu_op),
        .alu_operand_a_o        (alu_a),
        .alu_operand_b_o        (alu_b),
        .alu_instr_first_cycle_o(alu_first),
        .alu_imd_val_q_o        (imd_q),
        .alu_imd_val_d_i        (imd_d),
        .alu_imd_val_we_i       (imd_we),
        .alu_result_i           (alu_res),
        .grant_o                (grant),
        .busy_o                 (busy)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic set_req(input int r, input logic [6:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [1:0] n);
        req_op[r*OP_W +: OP_W] = op;
        req_a[r*32 +: 32]      = a;
        req_b[r*32 +: 32]      = b;
        req_ncyc[r*2 +: 2]     = n;
        req_valid[r]           = 1'b1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = '0;
        repeat (2) step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy && n < budget) begin
            step();
            n++;
        end
        check("idle_timeout", busy, 0);
    endtask

    // Response monitor: each handshake must match the oldest expected entry.
    initial begin
        forever begin
            @(negedge clk);
            if (resp_valid != 2'b00) begin
                check("resp_onehot", $countones(resp_valid), 1);
                if ((resp_valid & resp_ready) != 2'b00) begin
                    if (exp_q.size() == 0) begin
                        check("resp_unexpected", {31'd0, resp_valid}, 0);
                    end else begin
                        logic [32:0] e;
                        e = exp_q.pop_front();
                        check("resp_owner", {62'd0, resp_valid}, 64'(2'b01 << e[32]));
                        check("resp_result", resp_result, e[31:0]);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) step();
        smp();
        check("rst_grant", grant, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", req_ready, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_result", resp_result, 0);
        check("rst_alu", {alu_op, alu_a, alu_b, alu_first}, 0);
        check("rst_imd", imd_q, 0);
        rst_n = 1'b1;
        step();

        // 1: single ADD, one cycle
        set_req(0, OP_ADD, 32'd5, 32'd7, 2'd1);
        smp();
        check("t1_ready", req_ready, 2'b01);
        exp_q.push_back({1'b0, 32'd12});
        step();
        req_valid = '0;
        smp();
        check("t1_first", alu_first, 1);
        check("t1_grant", grant, 2'b01);
        check("t1_ready_exec", req_ready, 0);
        check("t1_opa", alu_a, 5);
        check("t1_opb", alu_b, 7);
        step();
        smp();
        check("t1_resp_valid", resp_valid, 2'b01);
        step();

        // 2: both valid after reset, req0 wins, then req1, then req0 again
        do_reset();
        set_req(0, OP_ADD, 32'd1, 32'd1, 2'd1);
        set_req(1, OP_SUB, 32'd9, 32'd4, 2'd1);
        smp();
        check("t2_ready_first", req_ready, 2'b01);
        exp_q.push_back({1'b0, 32'd2});
        step();
        req_valid[0] = 1'b0;
        smp();
        check("t2_ready_busy", req_ready, 0);
        step();
        step();
        smp();
        check("t2_ready_second", req_ready, 2'b10);
        exp_q.push_back({1'b1, 32'd5});
        step();
        req_valid[1] = 1'b0;
        wait_idle(10);
        set_req(0, OP_ADD, 32'd3, 32'd3, 2'd1);
        set_req(1, OP_SUB, 32'd8, 32'd2, 2'd1);
        smp();
        check("t2_ready_rr", req_ready, 2'b01);
        exp_q.push_back({1'b0, 32'd6});
        exp_q.push_back({1'b1, 32'd6});
        step();
        req_valid[0] = 1'b0;
        begin
            int n = 0;
            while (!req_ready[1] && n < 10) begin
                smp();
                if (!req_ready[1]) step();
                n++;
            end
            check("t2_req1_served", req_ready[1], 1);
        end
        step();
        req_valid = '0;
        wait_idle(10);

        // 3: req1, two cycles, intermediate value written in cycle 1
        set_req(1, OP_ADD, 32'd3, 32'd4, 2'd2);
        smp();
        check("t3_ready", req_ready, 2'b10);
        exp_q.push_back({1'b1, 32'd7});
        step();
        req_valid = '0;
        imd_we = 2'b01;
        imd_d = 64'h0000_0000_0000_00A5;
        smp();
        check("t3_first_c1", alu_first, 1);
        step();
        imd_we = 2'b00;
        imd_d = '0;
        smp();
        check("t3_imd", imd_q, 64'hA5);
        check("t3_first_c2", alu_first, 0);
        check("t3_no_resp_c2", resp_valid, 0);
        step();
        smp();
        check("t3_resp_valid", resp_valid, 2'b10);
        step();

        // 4: backpressure on req0 while req1 waits
        resp_ready = 2'b00;
        set_req(0, OP_ADD, 32'd10, 32'd20, 2'd1);
        smp();
        check("t4_ready0", req_ready, 2'b01);
        exp_q.push_back({1'b0, 32'd30});
        step();
        req_valid[0] = 1'b0;
        set_req(1, OP_SUB, 32'd50, 32'd8, 2'd1);
        step();
        for (int i = 0; i < 5; i++) begin
            smp();
            check("t4_hold_valid", resp_valid, 2'b01);
            check("t4_hold_result", resp_result, 30);
            check("t4_hold_ready1", req_ready, 0);
            step();
        end
        resp_ready = 2'b01;
        smp();
        check("t4_ready1_at_hs", req_ready, 0);
        step();
        resp_ready = 2'b11;
        smp();
        check("t4_ready1_after", req_ready, 2'b10);
        exp_q.push_back({1'b1, 32'd42});
        step();
        req_valid = '0;
        wait_idle(10);

        // 6: ncyc clamping
        set_req(0, OP_ADD, 32'd2, 32'd2, 2'd0);
        smp();
        check("t6a_ready", req_ready, 2'b01);
        exp_q.push_back({1'b0, 32'd4});
        step();
        req_valid = '0;
        smp();
        check("t6a_first", alu_first, 1);
        check("t6a_imd_clear", imd_q, 0);
        step();
        smp();
        check("t6a_resp_valid", resp_valid, 2'b01);
        step();
        set_req(0, OP_SUB, 32'd100, 32'd1, 2'd3);
        smp();
        check("t6b_ready", req_ready, 2'b01);
        exp_q.push_back({1'b0, 32'd99});
        step();
        req_valid = '0;
        smp();
        check("t6b_first", alu_first, 1);
        step();
        smp();
        check("t6b_first_c2", alu_first, 0);
        check("t6b_no_resp_c2", resp_valid, 0);
        step();
        smp();
        check("t6b_resp_valid", resp_valid, 2'b01);
        step();

        // 5: reset during EXEC aborts the op
        set_req(0, OP_ADD, 32'd1, 32'd2, 2'd2);
        smp();
        check("t5_ready", req_ready, 2'b01);
        step();
        req_valid = '0;
        rst_n = 1'b0;
        #1;
        check("t5_busy", busy, 0);
        check("t5_grant", grant, 0);
        check("t5_alu", {alu_op, alu_a, alu_b, alu_first}, 0);
        check("t5_result", resp_result, 0);
        check("t5_resp_valid", resp_valid, 0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            smp();
            check("t5_no_resp", resp_valid, 0);
            step();
        end
        set_req(0, OP_ADD, 32'd6, 32'd1, 2'd1);
        set_req(1, OP_ADD, 32'd6, 32'd2, 2'd1);
        smp();
        check("t5_ready_after", req_ready, 2'b01);
        exp_q.push_back({1'b0, 32'd7});
        step();
        req_valid = '0;
        wait_idle(10);
        repeat (2) step();

        check("queue_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
